// File: rtl/dwt97_lifting_step.sv
// dwt97_lifting_step
//   One lifting step (predict or update) of the 9/7 wavelet transform on an
//   interleaved 1-D sample stream (even index = low band, odd index = high).
//   Target samples become y[i] = x[i] + ((Kint * (x[i-1] + x[i+1])) >>> KPoint),
//   wrapped to DataWidth bits; all other samples pass through unchanged.
//   Line edges use symmetric extension. Sample order, sof and eol are kept.
//
// Ports
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   s_ready_o  input ready
//   s_valid_i  input valid
//   s_sof_i    first sample of frame (carried with its sample)
//   s_eol_i    last sample of line (restarts sample indexing)
//   s_data_i   input sample, signed
//   m_ready_i  output ready
//   m_valid_o  output valid
//   m_sof_o    sof of the output sample
//   m_eol_o    eol of the output sample
//   m_data_o   output sample, signed
module dwt97_lifting_step #(
  parameter int  DataWidth = 16,
  parameter int  KWidth    = 18,
  parameter real K         = -1.586134342,
  parameter int  KPoint    = 14,
  parameter bit  UpdateOdd = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 s_ready_o,
  input  logic                 s_valid_i,
  input  logic                 s_sof_i,
  input  logic                 s_eol_i,
  input  logic [DataWidth-1:0] s_data_i,
  input  logic                 m_ready_i,
  output logic                 m_valid_o,
  output logic                 m_sof_o,
  output logic                 m_eol_o,
  output logic [DataWidth-1:0] m_data_o
);

  // Fixed-point coefficient, truncated toward zero.
  localparam int KIntVal = $rtoi(K * (2.0 ** KPoint));
  localparam logic signed [KWidth-1:0] KInt = KWidth'(KIntVal);
  localparam int PW = DataWidth + KWidth + 1;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FLUSH
  } state_t;

  state_t state, state_n;

  // hold: sample waiting for its right neighbour; prev: sample before hold.
  logic [DataWidth-1:0] hold, prev;
  logic                 hold_sof;
  logic                 hold_odd;    // line-index parity of hold
  logic                 hold_first;  // hold is x[0] of its line

  logic [DataWidth-1:0] out_data;
  logic                 out_sof, out_eol, out_valid;

  logic                 out_free, accept;
  logic                 load_hold, first_load, load_out;
  logic [DataWidth-1:0] out_data_n;
  logic                 out_sof_n, out_eol_n;

  // Lifting datapath
  logic signed [DataWidth-1:0] lift_x, lift_a, lift_b, lift_y;
  logic signed [DataWidth:0]   nsum;
  logic signed [PW-1:0]        prod;
  logic                        target;
  logic [DataWidth-1:0]        y;

  assign out_free = !out_valid || m_ready_i;

  always_comb begin
    case (state)
      EMPTY:   s_ready_o = 1'b1;
      FILL:    s_ready_o = out_free;
      default: s_ready_o = 1'b0;
    endcase
  end

  assign accept = s_valid_i && s_ready_o;

  // Neighbours of hold: in FILL the right one is the incoming beat and the
  // left one is prev, except for x[0] which mirrors its right neighbour.
  // In FLUSH hold is the last sample and mirrors prev on both sides.
  always_comb begin
    lift_x = $signed(hold);
    if (state == FLUSH) begin
      lift_a = $signed(prev);
      lift_b = $signed(prev);
    end else begin
      lift_a = hold_first ? $signed(s_data_i) : $signed(prev);
      lift_b = $signed(s_data_i);
    end
    nsum   = {lift_a[DataWidth-1], lift_a} + {lift_b[DataWidth-1], lift_b};
    prod   = PW'(nsum) * PW'(KInt);
    lift_y = lift_x + DataWidth'(prod >>> KPoint);
    target = (hold_odd == UpdateOdd);
    y      = target ? lift_y : hold;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    load_hold  = 1'b0;
    first_load = 1'b0;
    load_out   = 1'b0;
    out_data_n = '0;
    out_sof_n  = 1'b0;
    out_eol_n  = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          if (s_eol_i) begin
            // Single-sample line: nothing to lift, forward as-is when the
            // output stage can take it.
            if (out_free) begin
              load_out   = 1'b1;
              out_data_n = s_data_i;
              out_sof_n  = s_sof_i;
              out_eol_n  = 1'b1;
            end
          end else begin
            load_hold  = 1'b1;
            first_load = 1'b1;
            state_n    = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          load_out   = 1'b1;
          out_data_n = y;
          out_sof_n  = hold_sof;
          load_hold  = 1'b1;
          if (s_eol_i) begin
            state_n = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          load_out   = 1'b1;
          out_data_n = y;
          out_sof_n  = hold_sof;
          out_eol_n  = 1'b1;
          state_n    = EMPTY;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold       <= '0;
      prev       <= '0;
      hold_sof   <= 1'b0;
      hold_odd   <= 1'b0;
      hold_first <= 1'b0;
    end else if (load_hold) begin
      prev       <= hold;
      hold       <= s_data_i;
      hold_sof   <= s_sof_i;
      hold_odd   <= first_load ? 1'b0 : ~hold_odd;
      hold_first <= first_load;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_data  <= out_data_n;
      out_sof   <= out_sof_n;
      out_eol   <= out_eol_n;
    end else if (m_ready_i) begin
      out_valid <= 1'b0;
    end
  end

  assign m_valid_o = out_valid;
  assign m_data_o  = out_data;
  assign m_sof_o   = out_sof;
  assign m_eol_o   = out_eol;

endmodule

// File: tb/tb_dwt97_lifting_step.sv
// Testbench for dwt97_lifting_step: five instances with different
// coefficient / role settings share one input stream and one m_ready.
// Each output is compared with a whole-stream index-based reference model.
module tb_dwt97_lifting_step;
  localparam int N = 5;
  localparam int MaxBeats = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0;
  logic [15:0] s_data = '0;
  logic m_ready = 1'b1;
  logic rand_rdy = 1'b0;

  logic sr[N], mv[N], ms[N], me[N];
  logic [15:0] md[N];

  int    upd[N] = '{1, 0, 1, 1, 0};
  real   kk[N]  = '{0.5, 0.5, -0.5, -1.586134342, -1.586134342};
  int    kp[N]  = '{10, 10, 10, 14, 14};
  longint kint[N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dwt97_lifting_step #(.DataWidth(16), .KWidth(18), .K(0.5), .KPoint(10), .UpdateOdd(1'b1)) u0 (
    .clk_i(clk), .rst_i(rst), .s_ready_o(sr[0]), .s_valid_i(s_valid), .s_sof_i(s_sof),
    .s_eol_i(s_eol), .s_data_i(s_data), .m_ready_i(m_ready), .m_valid_o(mv[0]),
    .m_sof_o(ms[0]), .m_eol_o(me[0]), .m_data_o(md[0]));
  dwt97_lifting_step #(.DataWidth(16), .KWidth(18), .K(0.5), .KPoint(10), .UpdateOdd(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst), .s_ready_o(sr[1]), .s_valid_i(s_valid), .s_sof_i(s_sof),
    .s_eol_i(s_eol), .s_data_i(s_data), .m_ready_i(m_ready), .m_valid_o(mv[1]),
    .m_sof_o(ms[1]), .m_eol_o(me[1]), .m_data_o(md[1]));
  dwt97_lifting_step #(.DataWidth(16), .KWidth(18), .K(-0.5), .KPoint(10), .UpdateOdd(1'b1)) u2 (
    .clk_i(clk), .rst_i(rst), .s_ready_o(sr[2]), .s_valid_i(s_valid), .s_sof_i(s_sof),
    .s_eol_i(s_eol), .s_data_i(s_data), .m_ready_i(m_ready), .m_valid_o(mv[2]),
    .m_sof_o(ms[2]), .m_eol_o(me[2]), .m_data_o(md[2]));
  dwt97_lifting_step #(.DataWidth(16), .KWidth(18), .K(-1.586134342), .KPoint(14), .UpdateOdd(1'b1)) u3 (
    .clk_i(clk), .rst_i(rst), .s_ready_o(sr[3]), .s_valid_i(s_valid), .s_sof_i(s_sof),
    .s_eol_i(s_eol), .s_data_i(s_data), .m_ready_i(m_ready), .m_valid_o(mv[3]),
    .m_sof_o(ms[3]), .m_eol_o(me[3]), .m_data_o(md[3]));
  dwt97_lifting_step #(.DataWidth(16), .KWidth(18), .K(-1.586134342), .KPoint(14), .UpdateOdd(1'b0)) u4 (
    .clk_i(clk), .rst_i(rst), .s_ready_o(sr[4]), .s_valid_i(s_valid), .s_sof_i(s_sof),
    .s_eol_i(s_eol), .s_data_i(s_data), .m_ready_i(m_ready), .m_valid_o(mv[4]),
    .m_sof_o(ms[4]), .m_eol_o(me[4]), .m_data_o(md[4]));

  // Accepted input stream with line positions
  logic signed [15:0] in_d[MaxBeats];
  logic               in_sof[MaxBeats];
  logic               in_eol[MaxBeats];
  int                 in_pos[MaxBeats];
  int                 in_cnt = 0;
  int                 line_pos = 0;
  int                 oidx[N];

  logic        stall[N];
  logic [17:0] st_val[N];
  logic [17:0] cap0[$], cap1[$], cap2[$];
  int          cyc = 0;
  int          first_in_cyc = -1;
  int          last_out_cyc[N];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lift_model(input longint x, input longint a, input longint b,
                                             input longint ki, input int sh);
    longint p, r;
    p = ki * (a + b);
    r = x + (p >>> sh);
    return r[15:0];
  endfunction

  function automatic logic [15:0] exp_data(input int d, input int k);
    int p;
    longint a, b;
    p = in_pos[k];
    if ((upd[d] == 1) != (p % 2 == 1)) return in_d[k];
    a = (p == 0) ? longint'(in_d[k + 1]) : longint'(in_d[k - 1]);
    b = in_eol[k] ? longint'(in_d[k - 1]) : longint'(in_d[k + 1]);
    return lift_model(longint'(in_d[k]), a, b, kint[d], kp[d]);
  endfunction

  // Monitor / compare: signals are sampled mid-cycle, transfers happen at
  // the following rising edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      line_pos = 0;
      for (int d = 0; d < N; d++) begin
        oidx[d]  = in_cnt;
        stall[d] = 1'b0;
      end
    end else begin
      for (int d = 1; d < N; d++) begin
        if (sr[d] !== sr[0]) begin
          checks++; errors++;
          $display("FAIL ready_agree dut%0d: got %b expected %b", d, sr[d], sr[0]);
        end
      end
      if (s_valid && sr[0]) begin
        in_d[in_cnt]   = s_data;
        in_sof[in_cnt] = s_sof;
        in_eol[in_cnt] = s_eol;
        in_pos[in_cnt] = line_pos;
        line_pos = s_eol ? 0 : line_pos + 1;
        if (first_in_cyc < 0) first_in_cyc = cyc;
        in_cnt++;
      end
      for (int d = 0; d < N; d++) begin
        if (stall[d]) begin
          checks++;
          if (!mv[d] || {ms[d], me[d], md[d]} !== st_val[d]) begin
            errors++;
            $display("FAIL stable dut%0d: got v=%b %h expected v=1 %h", d, mv[d],
                     {ms[d], me[d], md[d]}, st_val[d]);
          end
        end
        if (mv[d] && m_ready) begin
          checks++;
          if (oidx[d] >= in_cnt) begin
            errors++;
            $display("FAIL spurious dut%0d: output %h with no pending input", d, md[d]);
          end else begin
            logic [17:0] e;
            e = {in_sof[oidx[d]], in_eol[oidx[d]], exp_data(d, oidx[d])};
            if ({ms[d], me[d], md[d]} !== e) begin
              errors++;
              $display("FAIL out dut%0d beat%0d: got sof/eol/data %b%b %0d expected %b%b %0d",
                       d, oidx[d], ms[d], me[d], $signed(md[d]), e[17], e[16], $signed(e[15:0]));
            end
            oidx[d]++;
          end
          if (d == 0) cap0.push_back({ms[d], me[d], md[d]});
          if (d == 1) cap1.push_back({ms[d], me[d], md[d]});
          if (d == 2) cap2.push_back({ms[d], me[d], md[d]});
          last_out_cyc[d] = cyc;
        end
        stall[d]  = mv[d] && !m_ready;
        st_val[d] = {ms[d], me[d], md[d]};
      end
    end
  end

  always @(posedge clk) begin
    #1;
    m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic push(input logic [15:0] d, input logic sof, input logic eol);
    int t;
    t = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
    forever begin
      @(negedge clk);
      if (sr[0]) break;
      t++;
      if (t > 200) begin
        checks++; errors++;
        $display("FAIL push_timeout: got no ready expected ready within 200 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic drain();
    bit done;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #2;
      done = 1'b1;
      for (int d = 0; d < N; d++) if (oidx[d] != in_cnt) done = 1'b0;
      if (done) return;
    end
    checks++; errors++;
    $display("FAIL drain_timeout: got outputs pending expected all %0d delivered", in_cnt);
  endtask

  task automatic chk_seq(input string name, input logic [17:0] q[$], input logic [15:0] ed[4],
                         input logic [3:0] esof, input logic [3:0] eeol, input int n);
    chk({name, "_len"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      chk($sformatf("%s_data%0d", name, i), q[i][15:0], ed[i]);
      chk($sformatf("%s_sof%0d", name, i), q[i][17], esof[i]);
      chk($sformatf("%s_eol%0d", name, i), q[i][16], eeol[i]);
    end
  endtask

  task automatic clear_caps();
    cap0.delete(); cap1.delete(); cap2.delete();
    first_in_cyc = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < N; d++) begin
      kint[d] = longint'($rtoi(kk[d] * (2.0 ** kp[d])));
      oidx[d] = 0;
      stall[d] = 1'b0;
      last_out_cyc[d] = 0;
    end

    // Model pins
    chk("pin_kint_default", kint[3], -25987);
    chk("pin_kint_half", kint[0], 512);
    chk("pin_lift_half", lift_model(20, 10, 30, 512, 10), 40);
    chk("pin_lift_floor", lift_model(0, 1, 0, -512, 10), 16'hFFFF);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      chk($sformatf("reset_state_dut%0d", d), {mv[d], ms[d], me[d], md[d]}, 0);
      chk($sformatf("reset_ready_dut%0d", d), sr[d], 1);
    end
    @(posedge clk); #1;

    // Basic line, both roles, with end-to-end timing
    clear_caps();
    push(16'd10, 1'b1, 1'b0); push(16'd20, 1'b0, 1'b0);
    push(16'd30, 1'b0, 1'b0); push(16'd40, 1'b0, 1'b1);
    drain();
    chk_seq("s1_odd", cap0, '{16'd10, 16'd40, 16'd30, 16'd70}, 4'b0001, 4'b1000, 4);
    chk_seq("s1_even", cap1, '{16'd30, 16'd20, 16'd60, 16'd40}, 4'b0001, 4'b1000, 4);
    chk("s1_latency", last_out_cyc[0] - first_in_cyc, 5);

    // Negative coefficient, floor rounding
    clear_caps();
    push(16'd1, 1'b1, 1'b0); push(16'd0, 1'b0, 1'b0);
    push(16'd0, 1'b0, 1'b0); push(16'd0, 1'b0, 1'b1);
    drain();
    chk_seq("s2_floor", cap2, '{16'd1, 16'hFFFF, 16'd0, 16'd0}, 4'b0001, 4'b1000, 4);

    // Wraparound
    clear_caps();
    push(16'd32767, 1'b1, 1'b0); push(16'd32767, 1'b0, 1'b1);
    drain();
    chk_seq("s3_wrap", cap0, '{16'd32767, 16'hFFFE, 16'd0, 16'd0}, 4'b0001, 4'b0010, 2);

    // Back-to-back L=2 lines
    clear_caps();
    push(16'd5, 1'b1, 1'b0); push(16'd3, 1'b0, 1'b1);
    push(16'd2, 1'b0, 1'b0); push(16'd4, 1'b0, 1'b1);
    drain();
    chk_seq("s4_l2", cap1, '{16'd8, 16'd3, 16'd6, 16'd4}, 4'b0001, 4'b1010, 4);

    // Random data and backpressure
    rand_rdy = 1'b1;
    for (int ln = 0; ln < 64; ln++) begin
      for (int i = 0; i < 8; i++) begin
        push(16'($urandom), (i == 0) && ($urandom_range(0, 1) == 1), i == 7);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
    rand_rdy = 1'b0;
    drain();
    for (int d = 0; d < N; d++) chk($sformatf("rand_count_dut%0d", d), oidx[d], in_cnt);

    // Mid-line reset
    push(16'd7, 1'b1, 1'b0); push(16'd8, 1'b0, 1'b0); push(16'd9, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      chk($sformatf("midreset_valid_dut%0d", d), mv[d], 0);
      chk($sformatf("midreset_ready_dut%0d", d), sr[d], 1);
    end
    @(posedge clk); #1;
    clear_caps();
    push(16'd10, 1'b1, 1'b0); push(16'd20, 1'b0, 1'b0);
    push(16'd30, 1'b0, 1'b0); push(16'd40, 1'b0, 1'b1);
    drain();
    chk_seq("s6_after_reset", cap0, '{16'd10, 16'd40, 16'd30, 16'd70}, 4'b0001, 4'b1000, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dwt97_lifting_step.md
Name: dwt97_lifting_step

Overview:
- One lifting step (predict or update) of the 9/7 DWT on an interleaved 1-D sample stream (even = low, odd = high).
- Cascaded four times, with the odd/even role alternating per stage; the last stage feeds the output scaling stage.
- Input and output are AXI-Stream style with sof/eol sidebands. Sample order and sideband placement are preserved.

Parameters:
- DataWidth, 16: input/output sample width, signed two's complement.
- KWidth, 18: signed coefficient width.
- K, -1.586134342: real lifting coefficient.
- KPoint, 14: fractional bits of the coefficient. Kint = $rtoi(K*2.0**KPoint), truncated toward zero.
- UpdateOdd, 1: 1 = modify odd samples from even neighbours; 0 = modify even samples from odd neighbours.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_ready_o  out  1  input ready
- s_valid_i  in  1  input valid
- s_sof_i  in  1  first sample of frame
- s_eol_i  in  1  last sample of line
- s_data_i  in  DataWidth  input sample
- m_ready_i  in  1  output ready
- m_valid_o  out  1  output valid
- m_sof_o  out  1  sof of the output sample
- m_eol_o  out  1  eol of the output sample
- m_data_o  out  DataWidth  output sample

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Line framing:
  - Line length L is even and ≥ 2 (caller guarantees this).
  - Sample index restarts at 0 (even) on the first beat after reset or after an eol beat.
  - sof is carried with its sample and does not affect indexing.
- Arithmetic (target samples):
  - y[i] = x[i] + ((Kint * (a + b)) >>> KPoint), where a and b are the neighbours x[i-1] and x[i+1].
  - Neighbour sum is DataWidth+1 bits; product is DataWidth+KWidth+1 bits.
  - >>> is an arithmetic shift (floor).
  - Result is the low DataWidth bits: wrap, no saturation.
- Non-target samples pass through unchanged.
- Symmetric extension at line edges:
  - UpdateOdd=1: the last sample x[L-1] uses x[L-2] as both neighbours.
  - UpdateOdd=0: the first sample x[0] uses x[1] as both neighbours.
- Handshake:
  - A beat transfers when valid & ready.
  - Output holds data/sof/eol stable while m_valid_o=1 and m_ready_i=0.
- Storage:
  - hold register: sample awaiting its right neighbour.
  - prev register: the sample before hold.
  - out register: registered output stage.
- FSM, three states:
  - EMPTY (reset state): nothing held. Accepting a beat loads hold → FILL. If that beat has eol (protocol error, L=1), pass it through unmodified → FLUSH not entered.
  - FILL: hold valid. Accepting beat x[i+1] computes y[i] from prev/hold/x[i+1] into out, shifts hold→prev, loads x[i+1]→hold.
    - If x[i+1] has eol → FLUSH.
  - FLUSH: s_ready_o=0. When out is free, load y[L-1] (mirrored or pass-through, with eol) → EMPTY.
- s_ready_o = (state != FLUSH) && (!m_valid_o || m_ready_i).
  - Exception: in EMPTY the out register is not needed, so s_ready_o = 1.
- Latency and throughput:
  - Output for x[i] (i < L-1) appears the cycle after x[i+1] is accepted.
  - y[L-1] appears one cycle after y[L-2] leaves the out register.
  - Throughput is L outputs per L+1 cycles per line with no backpressure.
- Reset (any time, including mid-line):
  - m_valid_o=0, m_sof_o=0, m_eol_o=0, m_data_o=0.
  - State EMPTY, hold/prev cleared; s_ready_o=1 in the cycle after reset deasserts.
  - Partial line is discarded.
- Simultaneous events:
  - Output pop and input push in the same cycle are allowed in FILL.
  - In FLUSH with m_ready_i=1, out reloads with y[L-1] in that same cycle.

Test Plan:
- UpdateOdd=1, K=0.5, KPoint=10 (Kint=512), line [10,20,30,40] with eol on 40, m_ready_i=1 → outputs 10,40,30,70; eol only on 70; L+1=5 cycles from first accept to last output.
- UpdateOdd=0, same K, line [10,20,30,40] → outputs 30,20,60,40; first sample uses the mirrored neighbour 20.
- UpdateOdd=1, K=-0.5 (Kint=-512), line [1,0,0,0] → outputs 1,-1,0,0 (floor of -0.5 to -1); DataWidth=16 input [32767,32767] with K=0.5 → second output wraps to -32768+32766.
- L=2 lines back-to-back with sof on the first line: UpdateOdd=0, [5,3] → 8,3; next line [2,4] → 6,4; sof only on 8; index restarts after each eol.
- Random m_ready_i (50%) over 64 lines of L=8 versus a golden model → bit-exact, no loss or duplication, outputs stable while stalled.
- Assert rst_i for one cycle after 3 beats of an L=8 line → m_valid_o=0 next cycle; a fresh line [10,20,30,40] then produces the first-scenario result.
